packet_flitizer: RTL
====================

PACKET_FLITIZER -- requirements
Module: packet_flitizer

Interface
REQ-001 Parameter ID_SIZE, default 8, width of src/dest node IDs.
REQ-002 Parameter DATA_WIDTH, default 128, packet payload width.
REQ-003 Parameter FLIT_WIDTH, default 32, flit payload width; NBODY = DATA_WIDTH/FLIT_WIDTH.
REQ-004 Parameter QDEPTH, default 2, packet buffer entries, power of 2, >= 2.
REQ-005 clock  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pkt_valid  input  1  core offers a packet.
REQ-008 pkt_ready  output  1  block can accept a packet this cycle.
REQ-009 pkt_src  input  ID_SIZE  source node ID.
REQ-010 pkt_dest  input  ID_SIZE  destination node ID.
REQ-011 pkt_data  input  DATA_WIDTH  packet payload.
REQ-012 flit_valid  output  1  flit_out holds a valid flit.
REQ-013 flit_ready  input  1  downstream ring node accepts the flit this cycle.
REQ-014 flit_out  output  FLIT_WIDTH+2  {type[1:0], payload[FLIT_WIDTH-1:0]}.
REQ-015 busy  output  1  high while buffer non-empty or a packet is mid-serialization.

Function
REQ-016 Elaboration SHALL fail if DATA_WIDTH mod FLIT_WIDTH != 0 or FLIT_WIDTH < 2*ID_SIZE.
REQ-017 Packet handshake: transfer occurs on a rising edge with pkt_valid && pkt_ready; {src,dest,data} is written to the FIFO tail.
REQ-018 pkt_ready SHALL equal !full; a tail dequeue in the same cycle SHALL NOT allow an enqueue when full.
REQ-019 Flit types: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL; exactly one HEAD, NBODY-1 BODY, one TAIL per packet (NBODY+1 flits total).
REQ-020 HEAD payload SHALL be {zeros, src, dest}, dest in bits [ID_SIZE-1:0], src in [2*ID_SIZE-1:ID_SIZE].
REQ-021 Body flit k (k = 0..NBODY-1) payload SHALL be data[k*FLIT_WIDTH +: FLIT_WIDTH], least-significant slice first; flit k = NBODY-1 carries TAIL type.
REQ-022 If NBODY == 1 the single data flit SHALL be TAIL.
REQ-023 FSM states IDLE, HEAD, DATA; IDLE->HEAD when FIFO non-empty; HEAD->DATA on flit accept; DATA stays, incrementing beat counter per accept; DATA->HEAD on TAIL accept if FIFO holds another packet, else DATA->IDLE.
REQ-024 flit_out and flit_valid SHALL be driven combinationally from FSM state, beat counter and FIFO head entry; flit_valid = (state != IDLE).
REQ-025 Once flit_valid is high, flit_valid and flit_out SHALL remain stable until accepted (flit_valid && flit_ready).
REQ-026 The FIFO head entry SHALL be dequeued on the edge accepting its TAIL flit.
REQ-027 Latency: packet accepted at edge N into an empty, idle block -> HEAD flit valid during cycle after edge N+1 (IDLE->HEAD registered at N+1).
REQ-028 Back-to-back packets SHALL have zero bubble: the HEAD of the next packet is valid the cycle after the previous TAIL is accepted.
REQ-029 flit_ready low SHALL stall the FSM with no state, counter or FIFO change.
REQ-030 FIFO pointers SHALL wrap modulo QDEPTH; count SHALL be ceil(log2(QDEPTH+1)) bits.
REQ-031 busy = (count != 0) || (state != IDLE).

Reset
REQ-032 While reset is high: state = IDLE, beat counter = 0, FIFO count/pointers = 0; thus flit_valid = 0, busy = 0, pkt_ready = 1.
REQ-033 Reset asserted mid-packet SHALL drop the partial packet and all buffered packets immediately (asynchronously); no further flits of them are emitted.
REQ-034 FIFO data storage need not be reset.

Verification
REQ-035 Single packet src=0, dest=2, data=128'h1234, flit_ready=1 -> flits {01,32'h0000_0002}, {00,32'h1234}, {00,0}, {00,0}, {10,0} on consecutive cycles; busy low after TAIL.
REQ-036 Backpressure: same packet, flit_ready low for 3 cycles after HEAD -> HEAD held stable 4 cycles, then remaining 4 flits in order.
REQ-037 Full buffer: 3 packets offered back-to-back with flit_ready=0 -> first two accepted, pkt_ready=0 on third until first TAIL accepted; third packet accepted on the cycle after that dequeue.
REQ-038 Back-to-back: two packets (dest 1, dest 3) queued, flit_ready=1 -> 10 consecutive valid flits, second HEAD immediately after first TAIL.
REQ-039 Reset mid-packet after 2 flits accepted -> flit_valid=0 immediately, pkt_ready=1; new packet after release serializes from HEAD.
REQ-040 Data slice order: data=128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA -> body payloads AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD (TAIL).

Source files
------------

// File: rtl/packet_flitizer.sv
// Packet flitizer: buffers {src,dest,data} packets in a small FIFO and serializes
// each one as a HEAD flit followed by NBODY data flits, the last of which is TAIL.
module packet_flitizer #(
    parameter int ID_SIZE    = 8,
    parameter int DATA_WIDTH = 128,
    parameter int FLIT_WIDTH = 32,
    parameter int QDEPTH     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [ID_SIZE-1:0]      pkt_src,
    input  logic [ID_SIZE-1:0]      pkt_dest,
    input  logic [DATA_WIDTH-1:0]   pkt_data,
    output logic                    flit_valid,
    input  logic                    flit_ready,
    output logic [FLIT_WIDTH+1:0]   flit_out,
    output logic                    busy
);

    localparam int NBODY   = DATA_WIDTH / FLIT_WIDTH;
    localparam int BEAT_W  = (NBODY > 1) ? $clog2(NBODY) : 1;
    localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W   = $clog2(QDEPTH + 1);
    localparam int ENTRY_W = 2 * ID_SIZE + DATA_WIDTH;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    generate
        if (((DATA_WIDTH % FLIT_WIDTH) != 0) || (FLIT_WIDTH < 2 * ID_SIZE)) begin : g_bad_width
            $error("packet_flitizer: DATA_WIDTH must be a multiple of FLIT_WIDTH and FLIT_WIDTH >= 2*ID_SIZE");
        end
        if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_depth
            $error("packet_flitizer: QDEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAD = 2'b01,
        S_DATA = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ENTRY_W-1:0]      fifo_mem [QDEPTH];
    logic [ENTRY_W-1:0]      head_entry;
    logic [ID_SIZE-1:0]      head_src;
    logic [ID_SIZE-1:0]      head_dest;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    enq;
    logic                    deq;
    logic                    last_beat;

    assign pkt_ready  = (count_q != CNT_W'(QDEPTH));
    assign flit_valid = (state_q != S_IDLE);
    assign busy       = (count_q != {CNT_W{1'b0}}) || (state_q != S_IDLE);
    assign head_entry = fifo_mem[rd_ptr_q];
    assign {head_src, head_dest, head_data} = head_entry;

    // Next-state logic for the FIFO bookkeeping and the serializer FSM.
    always_comb begin
        last_beat = (beat_q == BEAT_W'(NBODY - 1));
        enq       = pkt_valid && pkt_ready;
        deq       = (state_q == S_DATA) && flit_ready && last_beat;
        wr_ptr_d  = enq ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = deq ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
        state_d   = state_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    state_d = S_HEAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEAD: begin
                if (flit_ready) begin
                    state_d = S_DATA;
                    beat_d  = {BEAT_W{1'b0}};
                end else begin
                    state_d = S_HEAD;
                end
            end
            S_DATA: begin
                if (flit_ready && last_beat) begin
                    // A packet landing in the same cycle still chains without a bubble.
                    state_d = (count_d != {CNT_W{1'b0}}) ? S_HEAD : S_IDLE;
                    beat_d  = {BEAT_W{1'b0}};
                end else if (flit_ready) begin
                    beat_d  = beat_q + BEAT_W'(1);
                end else begin
                    beat_d  = beat_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Outgoing flit built from the FSM state, beat counter and FIFO head entry.
    always_comb begin
        flit_out = {(FLIT_WIDTH + 2){1'b0}};
        case (state_q)
            S_HEAD: begin
                flit_out = {TYPE_HEAD, FLIT_WIDTH'({head_src, head_dest})};
            end
            S_DATA: begin
                if (last_beat) begin
                    flit_out = {TYPE_TAIL, head_data[beat_q * FLIT_WIDTH +: FLIT_WIDTH]};
                end else begin
                    flit_out = {TYPE_BODY, head_data[beat_q * FLIT_WIDTH +: FLIT_WIDTH]};
                end
            end
            default: begin
                flit_out = {(FLIT_WIDTH + 2){1'b0}};
            end
        endcase
    end

    // Control state with asynchronous reset; reset discards any partial or buffered packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            beat_q   <= {BEAT_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= {pkt_src, pkt_dest, pkt_data};
        end
    end

endmodule
